al_accel_bpbuf_unpack: RTL

Downstream consumer of the accelerator bypass buffer. Accepts 32-bit words from the bypass-buffer output under a valid/ready handshake. Serialises each word into 8-bit pixels, least-significant byte first, and streams them to the accelerator datapath until a programmed pixel count is reached. The final word may be partially consumed.

---
 rtl/al_accel_bpbuf_unpack_if.sv | 36 +++
 rtl/al_accel_bpbuf_unpack.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/al_accel_bpbuf_unpack_if.sv
// al_accel_bpbuf_unpack_if
//   Control, word-side and pixel-side signals of the bypass-buffer unpacker.
//   master : the environment (drives control, words, px_rdy).
//   slave  : the unpacker (drives word_rdy, pixels, status).
//   enb/start/len       stage enable, transfer start pulse, pixel count
//   word_di/vld/rdy     32-bit words from the bypass buffer
//   px_do/vld/rdy/last  pixel stream to the accelerator datapath
//   busy/done           transfer status
interface al_accel_bpbuf_unpack_if #(
  parameter int DW    = 32,
  parameter int PW    = 8,
  parameter int LEN_W = 16
);
  logic             enb;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [DW-1:0]    word_di;
  logic             word_vld;
  logic             word_rdy;
  logic [PW-1:0]    px_do;
  logic             px_vld;
  logic             px_rdy;
  logic             px_last;
  logic             busy;
  logic             done;

  modport master (
    output enb, start, len, word_di, word_vld, px_rdy,
    input  word_rdy, px_do, px_vld, px_last, busy, done
  );

  modport slave (
    input  enb, start, len, word_di, word_vld, px_rdy,
    output word_rdy, px_do, px_vld, px_last, busy, done
  );
endinterface

// File: rtl/al_accel_bpbuf_unpack.sv
// al_accel_bpbuf_unpack
//   Takes DW-bit words from the bypass buffer and serialises them into PW-bit
//   pixels, least-significant lane first, until len pixels have been sent.
//   The last word may be only partly used; its leftover lanes are dropped.
//   Ports:
//     clk     rising-edge clock
//     resetn  asynchronous active-low reset
//     bus     al_accel_bpbuf_unpack_if.slave (control, word and pixel sides)

// One lane of the output select: passes its byte when it is the active lane.
module al_accel_bpbuf_unpack_lane #(
  parameter int PW     = 8,
  parameter int LANE_W = 2,
  parameter int IDX    = 0
) (
  input  logic [LANE_W-1:0] lane_sel,
  input  logic [PW-1:0]     lane_px,
  output logic [PW-1:0]     lane_out
);
  assign lane_out = (lane_sel == LANE_W'(IDX)) ? lane_px : '0;
endmodule

module al_accel_bpbuf_unpack #(
  parameter int DW    = 32,
  parameter int PW    = 8,
  parameter int LEN_W = 16
) (
  input logic                     clk,
  input logic                     resetn,
  al_accel_bpbuf_unpack_if.slave  bus
);
  localparam int NUM_LANES = DW / PW;
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t                        state_q;
  logic [LEN_W-1:0]              rem_q;
  logic [LANE_W-1:0]             lane_q;
  logic [NUM_LANES-1:0][PW-1:0]  word_q;
  logic [NUM_LANES-1:0][PW-1:0]  lane_out;
  logic [PW-1:0]                 px_sel;

  // Registered state decodes; these, not combinational logic on the
  // handshake inputs, feed the outputs.
  logic fetch_q, emit_q, done_q, busy_q, last_q;
  logic px_vld;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    al_accel_bpbuf_unpack_lane #(.PW(PW), .LANE_W(LANE_W), .IDX(g)) u_lane (
      .lane_sel (lane_q),
      .lane_px  (word_q[g]),
      .lane_out (lane_out[g])
    );
  end

  always_comb begin
    px_sel = '0;
    for (int i = 0; i < NUM_LANES; i++) px_sel |= lane_out[i];
  end

  // enb gates every handshake strobe so nothing completes while frozen.
  assign px_vld       = emit_q & bus.enb;
  assign bus.px_vld   = px_vld;
  assign bus.word_rdy = fetch_q & bus.enb;
  assign bus.done     = done_q & bus.enb;
  assign bus.px_last  = last_q & bus.enb;
  assign bus.busy     = busy_q;
  assign bus.px_do    = px_vld ? px_sel : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      fetch_q <= 1'b0;
      emit_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (bus.enb) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              rem_q   <= bus.len;
              state_q <= FETCH;
              fetch_q <= 1'b1;
            end else begin
              // Zero-length transfer: report completion without fetching.
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (bus.word_vld) begin
            word_q  <= bus.word_di;
            lane_q  <= '0;
            state_q <= EMIT;
            fetch_q <= 1'b0;
            emit_q  <= 1'b1;
            last_q  <= (rem_q == LEN_W'(1));
          end
        end
        EMIT: begin
          if (bus.px_rdy) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= DONE;
              emit_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (lane_q == LANE_W'(NUM_LANES - 1)) begin
              // Word exhausted; lane is reloaded to 0 when the next word lands.
              state_q <= FETCH;
              emit_q  <= 1'b0;
              last_q  <= 1'b0;
              fetch_q <= 1'b1;
            end else begin
              lane_q <= lane_q + LANE_W'(1);
              last_q <= (rem_q == LEN_W'(2));
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          fetch_q <= 1'b0;
          emit_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
